// File: rtl/priority_arbiter_n.sv
// priority_arbiter_n: N-way arbiter with fixed-priority or round-robin selection.
// A grant is held for as long as its owner keeps requesting. When the owner
// drops, the grant moves straight to the next winner, or the arbiter goes idle.
// Optional feature macro: ARB_TIMEOUT_EN. It adds an 8-bit hold counter that
// forcibly revokes a contended grant after HOLD_MAX cycles.
module priority_arbiter_n #(
    parameter int N        = 3,
    parameter int RR_MODE  = 0,
    parameter int HOLD_MAX = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N-1:0]                          request,
    output logic [N-1:0]                          grants,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  grant_idx,
    output logic                                  busy,
    output logic                                  timeout
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Reject illegal parameter combinations at elaboration time.
    if (N < 2 || N > 16) begin : g_bad_n
        $error("priority_arbiter_n: N must be in 2..16");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $error("priority_arbiter_n: HOLD_MAX must be in 2..255");
    end
    if (RR_MODE != 0 && RR_MODE != 1) begin : g_bad_mode
        $error("priority_arbiter_n: RR_MODE must be 0 or 1");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IW-1:0]  rr_ptr;       // first index searched on the next new grant
    logic [N-1:0]   mask;         // candidates for the next grant
    logic [N-1:0]   win_onehot;
    logic [IW-1:0]  win_idx;
    logic           win_any;
    logic           found;
    logic           owner_held;
    logic           hold_expired;
    logic           take_new;     // a new grant is issued at this edge
    logic           go_idle;      // the owner left and nobody else is waiting
    logic           revoke;       // the grant is forcibly moved at this edge
    int             start;
    int             j;

    // Pick the winner by searching from the start index and wrapping.
    // While a grant is held, the owner is excluded from the search. This stops a
    // revoked owner, or one that just dropped, from winning again.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves a latch.
        mask       = (state == GRANT) ? (request & ~grants) : request;
        win_any    = |mask;
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        start      = (RR_MODE != 0) ? int'(rr_ptr) : 0;
        j          = 0;
        for (int off = 0; off < N; off++) begin
            j = start + off;
            if (j >= N) j = j - N;
            if (mask[j] && !found) begin
                found         = 1'b1;
                win_onehot[j] = 1'b1;
                win_idx       = IW'(j);
            end
        end
    end

    // Decide what happens at the coming edge: new grant, go idle, or hold.
    always_comb begin
        owner_held = |(request & grants);
        take_new   = 1'b0;
        go_idle    = 1'b0;
        revoke     = 1'b0;
        if (state == IDLE) begin
            take_new = win_any;
        end else if (!owner_held) begin
            take_new = win_any;
            go_idle  = !win_any;
        end else if (hold_expired && win_any) begin
            take_new = 1'b1;
            revoke   = 1'b1;
        end
    end

    // Arbiter FSM with registered grant outputs and the round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state     <= IDLE;
            grants    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
        end else if (take_new) begin
            state     <= GRANT;
            grants    <= win_onehot;
            grant_idx <= win_idx;
            busy      <= 1'b1;
            rr_ptr    <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
        end else if (go_idle) begin
            state     <= IDLE;
            grants    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // The counter can run past the limit while nobody else is waiting.
    // A contender that arrives later must still trigger revocation.
    assign hold_expired = (hold_cnt >= 8'(HOLD_MAX - 1));

    // Hold counter clears on each new grant and saturates while held. It also
    // produces the one-cycle revocation pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= revoke;
            if (take_new) begin
                hold_cnt <= '0;
            end else if (state == GRANT && hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_priority_arbiter_n.sv
// tb_priority_arbiter_n: directed and random checks of priority_arbiter_n (N=3).
// u_fix is built in fixed-priority mode with HOLD_MAX=4. u_rr is built in
// round-robin mode.
module tb_priority_arbiter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_f = '0;
    logic [2:0] req_r = '0;
    logic [2:0] g_f, g_r;
    logic [1:0] gi_f, gi_r;
    logic       b_f, b_r, to_f, to_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    priority_arbiter_n #(.N(3), .RR_MODE(0), .HOLD_MAX(4)) u_fix (
        .clk(clk), .rst(rst), .request(req_f),
        .grants(g_f), .grant_idx(gi_f), .busy(b_f), .timeout(to_f)
    );

    priority_arbiter_n #(.N(3), .RR_MODE(1), .HOLD_MAX(16)) u_rr (
        .clk(clk), .rst(rst), .request(req_r),
        .grants(g_r), .grant_idx(gi_r), .busy(b_r), .timeout(to_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] idx_of(input logic [2:0] g);
        idx_of = g[1] ? 2'd1 : (g[2] ? 2'd2 : 2'd0);
    endfunction

    task automatic check_f(input string tag, input logic [2:0] g, input logic [1:0] gi, input logic b);
        check({tag, "_grants"}, g_f, g);
        check({tag, "_idx"}, gi_f, gi);
        check({tag, "_busy"}, b_f, b);
    endtask

    logic [2:0] prev_g, prev_req;

    initial begin
        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        check_f("reset", 3'b000, 2'd0, 1'b0);
        check("reset_timeout", to_f, 0);
        check("reset_rr_grants", g_r, 3'b000);

        // Fixed mode: all requesters request, so the lowest index wins. Then
        // the owner drops.
        req_f = 3'b111; tick();
        check_f("fix_111", 3'b001, 2'd0, 1'b1);
        req_f = 3'b110; tick();
        check_f("fix_drop0", 3'b010, 2'd1, 1'b1);
        tick();
        check_f("fix_hold", 3'b010, 2'd1, 1'b1);

        // Reset during a grant revokes it. The request is ignored during reset.
        rst = 1'b1; tick();
        check_f("fix_rst_grant", 3'b000, 2'd0, 1'b0);
        rst = 1'b0; tick();
        check_f("fix_after_rst", 3'b010, 2'd1, 1'b1);

        // Owner drops with nothing pending. Then a lone high-index request arrives.
        req_f = 3'b000; tick();
        check_f("fix_idle", 3'b000, 2'd0, 1'b0);
        tick();
        check_f("fix_stay_idle", 3'b000, 2'd0, 1'b0);
        req_f = 3'b100; tick();
        check_f("fix_100", 3'b100, 2'd2, 1'b1);
        req_f = 3'b110; tick();
        check_f("fix_no_preempt", 3'b100, 2'd2, 1'b1);
        req_f = 3'b010; tick();
        check_f("fix_handoff", 3'b010, 2'd1, 1'b1);
        req_f = 3'b000; tick();
        check_f("fix_idle2", 3'b000, 2'd0, 1'b0);
        req_f = 3'b110; tick();
        check_f("fix_110", 3'b010, 2'd1, 1'b1);
        req_f = 3'b000; tick();

`ifdef ARB_TIMEOUT_EN
        // Contended hold: the grant stays for HOLD_MAX cycles, then is revoked
        // with a one-cycle timeout pulse.
        req_f = 3'b011;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_hold_grants", g_f, 3'b001);
            check("to_hold_timeout", to_f, 0);
        end
        tick();
        check("to_revoke_grants", g_f, 3'b010);
        check("to_revoke_timeout", to_f, 1);
        tick();
        check("to_after_grants", g_f, 3'b010);
        check("to_after_timeout", to_f, 0);
        req_f = 3'b001;
        tick();
        check("to_solo_grant", g_f, 3'b001);
        for (int i = 0; i < 22; i++) begin
            tick();
            check("to_solo_hold", g_f, 3'b001);
            check("to_solo_timeout", to_f, 0);
        end
`else
        // Without the timeout feature, a contended owner holds indefinitely.
        req_f = 3'b011;
        tick();
        check("nt_grant", g_f, 3'b001);
        for (int i = 0; i < 22; i++) begin
            tick();
            check("nt_hold", g_f, 3'b001);
            check("nt_timeout", to_f, 0);
        end
`endif
        req_f = 3'b000; tick();
        check_f("fix_final_idle", 3'b000, 2'd0, 1'b0);

        // Round-robin: each owner drops once, so the grant rotates and then wraps.
        req_r = 3'b111; tick();
        check("rr_first", g_r, 3'b001);
        req_r = 3'b110; tick();
        check("rr_second", g_r, 3'b010);
        check("rr_second_idx", gi_r, 1);
        req_r = 3'b101; tick();
        check("rr_third", g_r, 3'b100);
        check("rr_third_idx", gi_r, 2);
        req_r = 3'b011; tick();
        check("rr_wrap", g_r, 3'b001);
        check("rr_wrap_idx", gi_r, 0);
        req_r = 3'b110; tick();
        check("rr_pre_rst", g_r, 3'b010);

        // Reset restarts the pointer at index 0.
        rst = 1'b1; tick();
        check("rr_rst_grants", g_r, 3'b000);
        check("rr_rst_idx", gi_r, 0);
        check("rr_rst_busy", b_r, 0);
        rst = 1'b0; req_r = 3'b111; tick();
        check("rr_after_rst", g_r, 3'b001);
        req_r = 3'b000; tick();

        // Random stream: check the structural invariants every cycle.
        prev_g   = g_f;
        prev_req = req_f;
        for (int c = 0; c < 1000; c++) begin
            req_f = 3'($urandom_range(0, 7));
            req_r = 3'($urandom_range(0, 7));
            prev_g   = g_f;
            prev_req = req_f;
            tick();
            check("rnd_onehot_f", 32'($onehot0(g_f)), 1);
            check("rnd_busy_f", b_f, (g_f != 3'b000));
            check("rnd_idx_f", gi_f, idx_of(g_f));
            check("rnd_onehot_r", 32'($onehot0(g_r)), 1);
            check("rnd_busy_r", b_r, (g_r != 3'b000));
            check("rnd_idx_r", gi_r, idx_of(g_r));
            if (prev_g != 3'b000 && (prev_req & prev_g) == 3'b000)
                check("rnd_no_regrant", g_f & prev_g, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_arbiter_n.md
PRIORITY_ARBITER_N -- requirements
Module: priority_arbiter_n

Interface
REQ-001 Parameter N, default 3: number of requesters; legal range 2..16.
REQ-002 Parameter RR_MODE, default 0: 0 selects fixed priority, 1 selects round-robin.
REQ-003 Parameter HOLD_MAX, default 16: maximum cycles a grant is held under contention; legal range 2..255; used only with ARB_TIMEOUT_EN.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- request  input  N  per-requester request level; held high while access is wanted.
- grants  output  N  registered, one-hot or zero; bit i means requester i owns the resource.
- grant_idx  output  max(1,$clog2(N))  binary index of the owner; 0 when grants==0.
- busy  output  1  high while in state GRANT.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without ARB_TIMEOUT_EN.

Function
REQ-005 FSM has two states, IDLE and GRANT; all outputs are registered, with no combinational path from request to grants.
REQ-006 Arbitration latency: request sampled at edge k drives grants valid after edge k.
REQ-007 IDLE: at an edge where request!=0, the winner is granted and the FSM enters GRANT. At an edge where request==0, the FSM stays in IDLE with grants=0.
REQ-008 Fixed mode (RR_MODE=0): lowest index wins; request 3'b110 grants 3'b010.
REQ-009 Round-robin mode (RR_MODE=1): the search starts at (last_owner+1) mod N and wraps; after reset the search starts at index 0.
REQ-010 GRANT: while request[owner]=1 (and no timeout), grants, grant_idx and busy hold unchanged.
REQ-011 GRANT: at an edge where request[owner]=0 and another request is pending, the grant moves directly to the new winner with no idle bubble.
REQ-012 GRANT: at an edge where request[owner]=0 and request==0, grants=0, busy=0, and the FSM returns to IDLE.
REQ-013 Round-robin pointer update: last_owner updates only when a new grant is issued.
REQ-014 Simultaneous owner drop and new requests resolve per REQ-011; the dropped owner is never re-granted in the same cycle.
REQ-015 grants is never multi-hot, and grants!=0 if and only if busy=1.

Reset
REQ-016 When rst=1 at an edge: state=IDLE, grants=0, grant_idx=0, busy=0, timeout=0, round-robin pointer=index 0 first, hold counter=0.
REQ-017 Reset asserted during GRANT revokes the grant at that edge.
REQ-018 request is ignored in any cycle where rst=1.
REQ-019 The first grant after rst deasserts appears one edge after request is sampled.

Configuration
REQ-020 Macro ARB_TIMEOUT_EN, when defined, compiles in an 8-bit hold counter.
REQ-021 Hold counter behaviour: it clears on each new grant and increments each GRANT cycle.
REQ-022 Forced revocation: when the counter equals HOLD_MAX-1 and any non-owner request is pending, at the next edge the grant moves to the winner, with the owner excluded from the search. timeout pulses high for 1 cycle at that edge.
REQ-023 Uncontended hold: if no other request is pending, the owner keeps the grant past HOLD_MAX with no timeout, and the counter saturates.
REQ-024 Without ARB_TIMEOUT_EN: no counter, timeout tied to 0, and the owner holds indefinitely per REQ-010.

Verification
REQ-025 N=3, fixed mode: reset, then request=3'b111 -> grants=3'b001 one edge later and busy=1; drop bit0 -> grants=3'b010 at the next edge.
REQ-026 N=3, RR_MODE=1, request held at 3'b111 with each owner dropping and re-raising its bit after 1 grant cycle -> grants sequence 001,010,100,001 (wrap verified).
REQ-027 Owner drops with request=0 -> grants=0 and busy=0 at that edge; the next request=3'b100 -> grants=3'b100 one edge later.
REQ-028 Assert rst for 1 cycle while grants=3'b010 -> grants=0, grant_idx=0, busy=0 after that edge; in RR mode the following 3'b111 grants 3'b001.
REQ-029 ARB_TIMEOUT_EN, HOLD_MAX=4, request=3'b011 held -> 001 for 4 cycles, then 010 with timeout=1 for 1 cycle; with request=3'b001 alone, 001 holds 20+ cycles with timeout=0.
REQ-030 Random request stream for 1000 cycles -> checker confirms grants is one-hot or zero, grants!=0 iff busy, and grant_idx matches grants every cycle.
